// File: rtl/arm_multicycle_core.sv
// Multicycle ARM-subset core with a single request/ready memory port shared by fetch and data accesses.
// Optional MUL instruction support is enabled by defining ARM_MC_MUL_EN.
module arm_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] Adr,
    output logic              MemReq,
    output logic              MemWrite,
    output logic [31:0]       WriteData,
    input  logic [31:0]       ReadData,
    input  logic              MemReady,
    output logic [3:0]        ALUFlags,
    output logic [3:0]        State
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_MUL    = 4'd10
    } state_e;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] a_q;
    logic [31:0] wd_q;
    logic [31:0] aluout_q;
    logic [31:0] data_q;
    logic [3:0]  alu_nzcv_q;
    logic [3:0]  nzcv_q;
    logic [31:0] rf_q [0:14];

    // Instruction field decode, always taken from the latched IR.
    logic [3:0] cmd;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
    logic       i_bit;
    logic       s_bit;
    logic       is_mul;

    assign cmd   = ir_q[24:21];
    assign rn    = ir_q[19:16];
    assign rd    = ir_q[15:12];
    assign rm    = ir_q[3:0];
    assign i_bit = ir_q[25];
    assign s_bit = ir_q[20];

`ifdef ARM_MC_MUL_EN
    assign is_mul = (ir_q[27:22] == 6'b000000) && (ir_q[7:4] == 4'b1001);
`else
    assign is_mul = 1'b0;
`endif

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cf;
            4'h3:    return !cf;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cf && !z;
            4'h9:    return !cf || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Register-file read ports; R15 reads as fetch address + 8.
    logic [3:0]  a_idx;
    logic [3:0]  wd_idx;
    logic [31:0] a_rd;
    logic [31:0] wd_rd;

    always_comb begin
        a_idx  = rn;
        wd_idx = (ir_q[27:26] == 2'b01) ? rd : rm;
        if (is_mul) begin
            a_idx  = rm;
            wd_idx = ir_q[11:8];
        end
        a_rd  = (a_idx == 4'd15) ? pc_q + 32'd4 : rf_q[a_idx];
        wd_rd = (wd_idx == 4'd15) ? pc_q + 32'd4 : rf_q[wd_idx];
    end

    // ALU: C/V come from add/sub only, logic ops keep the current C and V.
    logic [31:0] src_b;
    logic [32:0] alu_sum;
    logic [32:0] alu_diff;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic        dp_wr;
    logic        dp_fl;

    always_comb begin
        src_b    = (state_q == S_EXECI) ? {24'd0, ir_q[7:0]} : wd_q;
        alu_sum  = {1'b0, a_q} + {1'b0, src_b};
        alu_diff = {1'b0, a_q} + {1'b0, ~src_b} + 33'd1;
        alu_res  = 32'd0;
        alu_c    = nzcv_q[1];
        alu_v    = nzcv_q[0];
        dp_wr    = 1'b0;
        dp_fl    = 1'b0;
        case (cmd)
            CMD_ADD: begin
                alu_res = alu_sum[31:0];
                alu_c   = alu_sum[32];
                alu_v   = (a_q[31] == src_b[31]) && (alu_sum[31] != a_q[31]);
                dp_wr   = 1'b1;
                dp_fl   = s_bit;
            end
            CMD_SUB, CMD_CMP: begin
                alu_res = alu_diff[31:0];
                alu_c   = alu_diff[32];
                alu_v   = (a_q[31] != src_b[31]) && (alu_diff[31] != a_q[31]);
                dp_wr   = (cmd == CMD_SUB);
                dp_fl   = s_bit || (cmd == CMD_CMP);
            end
            CMD_AND: begin
                alu_res = a_q & src_b;
                dp_wr   = 1'b1;
                dp_fl   = s_bit;
            end
            CMD_ORR: begin
                alu_res = a_q | src_b;
                dp_wr   = 1'b1;
                dp_fl   = s_bit;
            end
            default: ;
        endcase
    end

    logic       wb_en;
    logic       fl_en;
    logic [3:0] wb_idx;

    assign wb_en  = is_mul || dp_wr;
    assign fl_en  = is_mul ? s_bit : dp_fl;
    assign wb_idx = is_mul ? ir_q[19:16] : rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            a_q        <= 32'd0;
            wd_q       <= 32'd0;
            aluout_q   <= 32'd0;
            data_q     <= 32'd0;
            alu_nzcv_q <= 4'd0;
            nzcv_q     <= 4'd0;
            for (int k = 0; k < 15; k++) begin
                rf_q[k] <= 32'd0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (MemReady) begin
                        ir_q    <= ReadData;
                        pc_q    <= pc_q + 32'd4;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q  <= a_rd;
                    wd_q <= wd_rd;
                    if (!cond_pass(ir_q[31:28], nzcv_q)) begin
                        state_q <= S_FETCH;
`ifdef ARM_MC_MUL_EN
                    end else if (is_mul) begin
                        state_q <= S_MUL;
`endif
                    end else begin
                        case (ir_q[27:26])
                            2'b00:   state_q <= i_bit ? S_EXECI : S_EXECR;
                            2'b01:   state_q <= S_MEMADR;
                            2'b10:   state_q <= S_BRANCH;
                            default: state_q <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: begin
                    aluout_q <= ir_q[23] ? a_q + {20'd0, ir_q[11:0]} : a_q - {20'd0, ir_q[11:0]};
                    state_q  <= s_bit ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (MemReady) begin
                        data_q  <= ReadData;
                        state_q <= S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    if (rd == 4'd15) begin
                        pc_q <= data_q;
                    end else begin
                        rf_q[rd] <= data_q;
                    end
                    state_q <= S_FETCH;
                end
                S_MEMWR: begin
                    if (MemReady) begin
                        state_q <= S_FETCH;
                    end
                end
                S_EXECR, S_EXECI: begin
                    aluout_q   <= alu_res;
                    alu_nzcv_q <= {alu_res[31], alu_res == 32'd0, alu_c, alu_v};
                    state_q    <= S_ALUWB;
                end
`ifdef ARM_MC_MUL_EN
                S_MUL: begin
                    aluout_q   <= a_q * wd_q;
                    alu_nzcv_q <= {(a_q * wd_q) >> 31 == 32'd1, (a_q * wd_q) == 32'd0, nzcv_q[1:0]};
                    state_q    <= S_ALUWB;
                end
`endif
                S_ALUWB: begin
                    if (wb_en) begin
                        if (wb_idx == 4'd15) begin
                            pc_q <= aluout_q;
                        end else begin
                            rf_q[wb_idx] <= aluout_q;
                        end
                    end
                    if (fl_en) begin
                        nzcv_q <= alu_nzcv_q;
                    end
                    state_q <= S_FETCH;
                end
                S_BRANCH: begin
                    pc_q <= pc_q + 32'd4 + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
                    if (ir_q[24]) begin
                        rf_q[14] <= pc_q;
                    end
                    state_q <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Memory port decoded straight from registered state so reset takes effect at once.
    assign MemReq    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign MemWrite  = (state_q == S_MEMWR);
    assign Adr       = (state_q == S_FETCH) ? pc_q[ADDR_W-1:0] : aluout_q[ADDR_W-1:0];
    assign WriteData = wd_q;
    assign ALUFlags  = nzcv_q;
    assign State     = state_q;

endmodule

// File: tb/tb_arm_multicycle_core.sv
// Bench for arm_multicycle_core: directed program plus random data-processing programs checked against an ISA-level model.
module tb_arm_multicycle_core;
    localparam logic [3:0] S_FETCH = 4'd0;
    localparam logic [3:0] S_MEMRD = 4'd3;
    localparam logic [3:0] S_MEMWR = 4'd5;
    localparam logic [3:0] AL      = 4'hE;
    localparam logic [3:0] C_ADD   = 4'b0100;
    localparam logic [3:0] C_SUB   = 4'b0010;
    localparam logic [3:0] C_AND   = 4'b0000;
    localparam logic [3:0] C_ORR   = 4'b1100;
    localparam logic [3:0] C_CMP   = 4'b1010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Adr;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
    logic [3:0]  ALUFlags;
    logic [3:0]  State;

    arm_multicycle_core #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .Adr(Adr), .MemReq(MemReq), .MemWrite(MemWrite),
        .WriteData(WriteData), .ReadData(ReadData), .MemReady(MemReady),
        .ALUFlags(ALUFlags), .State(State)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'd0;
    logic [31:0] ld_data = 32'd0;
    logic [31:0] last_wa = 32'd0;
    logic        rand_mode = 1'b0;
    logic        rnd_rdy = 1'b1;
    logic        dir_rdy = 1'b1;

    assign MemReady = rand_mode ? rnd_rdy : dir_rdy;
    assign ReadData = mem[Adr[9:2]];

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (MemReq && MemWrite && MemReady) begin
            mem[Adr[9:2]] <= WriteData;
            last_wa       <= Adr;
        end
    end

    always @(negedge clk) rnd_rdy = ($urandom_range(0, 3) != 0);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr[9:2];
        ld_data = data;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    // Runs one instruction from FETCH until the next FETCH, returning its cycle count.
    task automatic step(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (State == S_FETCH && cyc < 100);
        while (State != S_FETCH && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [31:0] dp(input logic [3:0] c, input logic [3:0] cmd, input logic i,
                                       input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [7:0] op2);
        return {c, 2'b00, i, cmd, s, rn, rd, 4'b0000, op2};
    endfunction

    function automatic logic [31:0] ldst(input logic [3:0] c, input logic l, input logic u,
                                         input logic [3:0] rn, input logic [3:0] rd,
                                         input logic [11:0] imm);
        return {c, 2'b01, 1'b0, 1'b1, u, 1'b0, 1'b0, l, rn, rd, imm};
    endfunction

    function automatic logic [31:0] br(input logic [3:0] c, input logic link, input logic [23:0] imm);
        return {c, 3'b101, link, imm};
    endfunction

    // ISA-level reference model for data-processing instructions.
    logic [31:0] m_r [0:15];
    logic [3:0]  m_f;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_exec(input logic [31:0] ins);
        logic [31:0] a, b, res;
        logic        c, v, wr, fl;
        longint      r;
        if (!cond_ok(ins[31:28], m_f)) return;
        a   = m_r[ins[19:16]];
        b   = ins[25] ? {24'd0, ins[7:0]} : m_r[ins[3:0]];
        c   = m_f[1];
        v   = m_f[0];
        wr  = 1'b1;
        fl  = ins[20];
        res = 32'd0;
        case (ins[24:21])
            C_ADD: begin
                res = a + b;
                c   = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
                r   = longint'($signed(a)) + longint'($signed(b));
                v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            C_SUB, C_CMP: begin
                res = a - b;
                c   = (a >= b);
                r   = longint'($signed(a)) - longint'($signed(b));
                v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                if (ins[24:21] == C_CMP) begin
                    wr = 1'b0;
                    fl = 1'b1;
                end
            end
            C_AND: res = a & b;
            C_ORR: res = a | b;
            default: begin
                wr = 1'b0;
                fl = 1'b0;
            end
        endcase
        if (wr) m_r[ins[15:12]] = res;
        if (fl) m_f = {res[31], res == 32'd0, c, v};
    endtask

    logic [31:0] prog [$];

    initial begin
        int          cyc;
        int          n;
        bit          done;
        logic [31:0] sa;
        logic [31:0] sw;
        logic [31:0] loop_addr;
        logic [3:0]  cmds [0:5];
        logic [3:0]  c;
        logic        imm;
        cmds[0] = C_ADD; cmds[1] = C_SUB; cmds[2] = C_AND;
        cmds[3] = C_ORR; cmds[4] = C_CMP; cmds[5] = 4'b1111;

        for (int k = 0; k < 256; k++) load(32'(k * 4), 32'd0);
        chk("rst_adr", Adr, 32'h0);
        chk("rst_memreq", 32'(MemReq), 32'd1);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_state", 32'(State), 32'(S_FETCH));
        chk("rst_flags", 32'(ALUFlags), 32'd0);

        load(32'h00, dp(AL, C_ADD, 1'b1, 1'b0, 4'd15, 4'd1, 8'h00));
        load(32'h04, dp(AL, C_ADD, 1'b1, 1'b0, 4'd0, 4'd0, 8'hFF));
        load(32'h08, dp(AL, C_ADD, 1'b1, 1'b0, 4'd0, 4'd0, 8'h01));
        load(32'h0C, ldst(AL, 1'b0, 1'b1, 4'd0, 4'd1, 12'h018));
        load(32'h10, dp(AL, C_SUB, 1'b1, 1'b0, 4'd1, 4'd1, 8'h03));
        load(32'h14, dp(AL, C_SUB, 1'b0, 1'b1, 4'd1, 4'd2, 8'h01));
        load(32'h18, br(4'h1, 1'b0, 24'h000010));
        load(32'h1C, ldst(AL, 1'b1, 1'b1, 4'd0, 4'd2, 12'h040));
        load(32'h20, ldst(AL, 1'b0, 1'b1, 4'd0, 4'd2, 12'h010));
        load(32'h24, ldst(AL, 1'b1, 1'b1, 4'd0, 4'd3, 12'h010));
        load(32'h28, ldst(AL, 1'b1, 1'b1, 4'd0, 4'd4, 12'h010));
        load(32'h2C, ldst(AL, 1'b0, 1'b1, 4'd0, 4'd3, 12'h014));
        load(32'h30, ldst(AL, 1'b0, 1'b1, 4'd0, 4'd4, 12'h01C));
        load(32'h34, br(AL, 1'b0, 24'h000001));
        load(32'h40, br(AL, 1'b1, 24'hFFFFFE));
        load(32'h80, ldst(AL, 1'b0, 1'b1, 4'd0, 4'd1, 12'h030));
        load(32'hC4, 32'h0000_0080);
        load(32'h140, 32'hDEAD_BEEF);

        reset = 1'b0;
        step(cyc); chk("add_r15_cycles", 32'(cyc), 32'd4); chk("add_next_adr", Adr, 32'h4);
        step(cyc); chk("add_imm_cycles", 32'(cyc), 32'd4);
        step(cyc);
        step(cyc); chk("str_r1_cycles", 32'(cyc), 32'd4);
        chk("str_r1_addr", last_wa, 32'h118); chk("r1_value", mem[32'h118 >> 2], 32'd8);
        step(cyc);
        step(cyc); chk("subs_flags", 32'(ALUFlags), 32'b0110);
        step(cyc); chk("bne_fail_cycles", 32'(cyc), 32'd2); chk("bne_next_adr", Adr, 32'h1C);
        step(cyc); chk("ldr_cycles", 32'(cyc), 32'd5);
        step(cyc); chk("str_cycles", 32'(cyc), 32'd4);
        chk("str_addr", last_wa, 32'h110); chk("str_data", mem[32'h110 >> 2], 32'hDEAD_BEEF);
        step(cyc); chk("ldr_r3_cycles", 32'(cyc), 32'd5);

        dir_rdy = 1'b0;
        cyc = 0;
        repeat (3) begin
            @(posedge clk); #1; cyc++;
            chk("stall_fetch_adr", Adr, 32'h28);
            chk("stall_fetch_req", 32'(MemReq), 32'd1);
            chk("stall_fetch_state", 32'(State), 32'(S_FETCH));
        end
        dir_rdy = 1'b1;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        chk("stall_memrd_state", 32'(State), 32'(S_MEMRD));
        dir_rdy = 1'b0;
        sw = WriteData;
        repeat (3) begin
            @(posedge clk); #1; cyc++;
            chk("stall_memrd_adr", Adr, 32'h110);
            chk("stall_memrd_req", 32'(MemReq), 32'd1);
            chk("stall_memrd_wdata", WriteData, sw);
        end
        dir_rdy = 1'b1;
        while (State != S_FETCH && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("stall_ldr_cycles", 32'(cyc), 32'd11);

        step(cyc); chk("ldr_r3_value", mem[32'h114 >> 2], 32'hDEAD_BEEF);
        step(cyc); chk("stall_ldr_value", mem[32'h11C >> 2], 32'hDEAD_BEEF);
        step(cyc); chk("b_cycles", 32'(cyc), 32'd3); chk("b_target", Adr, 32'h40);
        step(cyc); chk("bl_cycles", 32'(cyc), 32'd3); chk("bl_target", Adr, 32'h40);

        dir_rdy = 1'b0;
        load(32'h40, ldst(AL, 1'b0, 1'b1, 4'd0, 4'd14, 12'h020));
        load(32'h44, ldst(AL, 1'b1, 1'b0, 4'd0, 4'd15, 12'h03C));
        dir_rdy = 1'b1;
        step(cyc); chk("bl_link_r14", mem[32'h120 >> 2], 32'h44);
        step(cyc); chk("ldr_pc_cycles", 32'(cyc), 32'd5); chk("ldr_pc_target", Adr, 32'h80);

        @(posedge clk); #1;
        @(posedge clk); #1;
        dir_rdy = 1'b0;
        @(posedge clk); #1;
        chk("memwr_state", 32'(State), 32'(S_MEMWR));
        chk("memwr_we", 32'(MemWrite), 32'd1);
        chk("memwr_adr", Adr, 32'h130);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_we", 32'(MemWrite), 32'd0);
        chk("rst_mid_state", 32'(State), 32'(S_FETCH));
        chk("rst_mid_adr", Adr, 32'h0);
        chk("rst_mid_flags", 32'(ALUFlags), 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_nowrite", mem[32'h130 >> 2], 32'd0);
        dir_rdy = 1'b1;

        for (int p = 0; p < 4; p++) begin
            reset = 1'b1;
            rand_mode = (p >= 2);
            prog.delete();
            for (int i = 0; i < 8; i++)
                prog.push_back(dp(AL, ($urandom_range(0, 1) != 0) ? C_SUB : C_ADD, 1'b1, 1'b0,
                                  4'd8, 4'(i), 8'($urandom_range(0, 255))));
            for (int i = 0; i < 12; i++) begin
                c   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : AL;
                imm = 1'($urandom_range(0, 1));
                prog.push_back(dp(c, cmds[$urandom_range(0, 5)], imm, 1'($urandom_range(0, 1)),
                                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                                  imm ? 8'($urandom_range(0, 255)) : {4'd0, 4'($urandom_range(0, 7))}));
            end
            for (int i = 0; i < 8; i++)
                prog.push_back(ldst(AL, 1'b0, 1'b1, 4'd8, 4'(i), 12'(12'h200 + 4 * i)));
            loop_addr = 32'(prog.size() * 4);
            prog.push_back(br(AL, 1'b0, 24'hFFFFFE));
            for (int i = 0; i < prog.size(); i++) load(32'(i * 4), prog[i]);
            for (int i = 0; i < 8; i++) load(32'(32'h200 + 4 * i), 32'hA5A5_0000 + 32'(i));

            for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
            m_f = 4'd0;
            for (int i = 0; i < 20; i++) m_exec(prog[i]);

            reset = 1'b0;
            n = 0;
            done = 1'b0;
            while (!done && n < 3000) begin
                @(posedge clk); #1; n++;
                if (State == S_FETCH && Adr == loop_addr) done = 1'b1;
            end
            chk("rand_reach_loop", 32'(done), 32'd1);
            for (int i = 0; i < 8; i++)
                chk($sformatf("rand_p%0d_r%0d", p, i), mem[(32'h200 >> 2) + i], m_r[i]);
            chk($sformatf("rand_p%0d_nzcv", p), 32'(ALUFlags), 32'(m_f));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arm_multicycle_core.md
Name: arm_multicycle_core

Overview:
- Parametrised multicycle ARM subset core with one unified memory port. Instruction and data accesses share one Adr/ReadData/WriteData interface.
- Contains the datapath, a 16x32 register file, NZCV flags, and its own sequencing FSM.
- Memory accesses use a request/ready handshake, so wait states are supported.
- Sits between the top level and a single memory model. It is the next-generation replacement for the single-cycle datapath/controller pair.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of the Adr output (PC[ADDR_W-1:0], range 16..32); internal PC and registers stay 32 bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Adr  output  ADDR_W  memory address.
- MemReq  output  1  memory access request.
- MemWrite  output  1  write qualifier; valid only while MemReq=1.
- WriteData  output  32  store data.
- ReadData  input  32  read data; valid when MemReady=1.
- MemReady  input  1  access completes this cycle.
- ALUFlags  output  4  current NZCV register.
- State  output  4  FSM state, for debug/verification.

Behaviour:
- Reset:
  - Async reset sets PC=RESET_PC, State=FETCH, NZCV=0, all R0-R14=0, IR=0.
  - Outputs during reset: MemReq=1, MemWrite=0, Adr=RESET_PC, WriteData=0.
  - Reset mid-access abandons the access with no register or flag side effects.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH (+MUL under macro).
- FETCH:
  - Adr=PC, MemReq=1. Stays in FETCH while MemReady=0.
  - On MemReady: IR<=ReadData, PC<=PC+4, go to DECODE.
- DECODE:
  - Latches A=R[Rn] and WD=R[Rd or Rm]. Reads of R15 return PC+4, i.e. fetch address +8.
  - Evaluates cond[31:28] against NZCV: EQ..LE per ARM, AL=1110; 1111 counts as fail.
  - Fail goes to FETCH with no side effects.
- op[27:26]=00, data processing:
  - I=1 goes to EXECI (SrcB=zero-extended imm8); I=0 goes to EXECR (SrcB=R[Rm], no shift).
  - cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no writeback, flags always).
  - Other cmd values execute as a NOP.
  - EXEC latches ALUOut, then ALUWB writes Rd.
  - NZCV updates in ALUWB if S=1 or CMP. C/V are from add/sub only; AND/ORR keep C and V.
- op=01, LDR/STR:
  - MEMADR: ALUOut=A±imm12 (U bit 23 selects add/subtract).
  - L=1 goes to MEMRD: Adr=ALUOut, MemReq=1, wait for MemReady, latch Data, then MEMWB writes Rd.
  - L=0 goes to MEMWR: MemWrite=1, WriteData=WD, held stable until MemReady.
- op=10, B/BL: BRANCH sets PC<=PC+4+(sext(imm24)<<2). If bit24=1, R14<=PC (return address).
- op=11: NOP.
- Writeback to R15 from ALUWB or MEMWB loads PC with that value instead of a register write.
- Cycle counts with zero waits: DP 4, LDR 5, STR 4, B 3, failed condition 2. Each MemReady=0 cycle adds one cycle.
- MemReq=0 in all non-memory states. Adr in those states shows ALUOut and is don't-care.
- 32-bit arithmetic wraps: carry out goes to C, overflow to V. SUB computes A+~B+1, with C=1 meaning no borrow.
- PC wraps modulo 2^32.

Optional Feature:
- Macro: ARM_MC_MUL_EN.
- Defined:
  - IR[27:22]=000000 with IR[7:4]=1001 decodes as MUL Rd(19:16)=Rm(3:0)*Rs(11:8), low 32 bits.
  - Flow: DECODE → MUL (one cycle) → ALUWB.
  - S=1 updates N and Z; C and V are kept.
- Undefined: that encoding executes as a register-form AND. The MUL state and multiplier are absent.

Test Plan:
- Reset release, memory {0: ADD R1,R15,#0} → R1=8 after 4 cycles; PC=4; Adr=0 during reset.
- SUBS R2,R1,R1 with R1=5 → R2=0, NZCV=0110; then BNE → condition fails in 2 cycles, PC=next sequential.
- STR R2,[R0,#16] then LDR R3,[R0,#16] with R0=0x100, R2=0xDEADBEEF:
  - MemWrite=1 at Adr=0x110.
  - R3=0xDEADBEEF.
  - Each instruction's cycle count matches (4 and 5).
- MemReady low 3 cycles in FETCH and MEMRD → Adr, MemReq and WriteData stay stable. Instruction completes 3 cycles late per stall with correct result.
- BL with imm24=0xFFFFFE at 0x40 → PC=0x40, R14=0x44; LDR into R15 loads PC from memory.
- Reset asserted mid-MEMWR → MemWrite drops immediately; state FETCH, PC=RESET_PC, no register or flag change.
